// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a word-addressed memory.
// Serves one FIXED/INCR/WRAP burst at a time and supports full R backpressure.
// A backdoor port writes words at any time, including during reset.
// Handshake rule used on both channels: a transfer happens on a rising edge
// where valid and ready are both high. The R payload (rid, rdata, rresp,
// rlast) is registered and stays unchanged while rvalid is high and rready is low.
module axi_read_responder #(
    parameter int                    ID_WIDTH   = 13,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data
);

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BPB);
    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [ADDR_WIDTH-1:0] BPB_A   = ADDR_WIDTH'(BPB);
    localparam logic [ADDR_WIDTH-1:0] WORDS_A = ADDR_WIDTH'(MEM_WORDS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_e                state_q,   state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  rlast_q,   rlast_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [ID_WIDTH-1:0]   rid_q,     rid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [7:0]            len_q,     len_d;
    logic [1:0]            burst_q,   burst_d;
    logic                  err_q,     err_d;
    logic [7:0]            beat_q,    beat_d;

    logic                  ar_err;
    logic                  load;
    logic                  load_err;
    logic                  load_ok;
    logic [ADDR_WIDTH-1:0] load_addr;

    // Below-base addresses show up as a borrow out of the subtraction.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return !diff[ADDR_WIDTH] && ((diff[ADDR_WIDTH-1:0] >> SZ) < WORDS_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> SZ);
    endfunction

    // WRAP keeps the upper address bits and wraps the low bits inside the
    // (len+1)*BPB window; illegal WRAP lengths are errored, so their mask is moot.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] mask;
        mask = ((ADDR_WIDTH'(len) + 1) << SZ) - 1;
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~mask) | ((a + BPB_A) & mask);
            default:     return a + BPB_A;
        endcase
    endfunction

    // Whole-burst error: wrong beat size, reserved burst type or illegal WRAP length.
    always_comb begin
        ar_err = (s_axi_arsize != 3'(SZ)) ||
                 (s_axi_arburst == BURST_RSVD) ||
                 ((s_axi_arburst == BURST_WRAP) &&
                  !((s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                    (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15)));
    end

    // Next-state, beat sequencing and R output register load.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_d     = err_q;
        beat_d    = beat_q;
        load      = 1'b0;
        load_err  = err_q;
        load_addr = addr_q;
        load_ok   = 1'b0;

        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                if (s_axi_arvalid && arready_q) begin
                    state_d   = BURST;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = s_axi_arid;
                    len_d     = s_axi_arlen;
                    burst_d   = s_axi_arburst;
                    err_d     = ar_err;
                    beat_d    = 8'd0;
                    rlast_d   = (s_axi_arlen == 8'd0);
                    load      = 1'b1;
                    load_err  = ar_err;
                    load_addr = s_axi_araddr & ~(BPB_A - 1);
                end
            end
            BURST: begin
                arready_d = 1'b0;
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        beat_d    = beat_q + 8'd1;
                        rlast_d   = ((beat_q + 8'd1) == len_q);
                        load      = 1'b1;
                        load_addr = next_addr(addr_q, len_q, burst_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            load_ok = !load_err && in_range(load_addr);
            addr_d  = load_addr;
            rresp_d = load_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d = load_ok ? mem[word_idx(load_addr)] : '0;
        end
    end

    // Control and R-channel registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            beat_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
        end
    end

    // Backdoor write port; independent of reset so memory survives it and
    // can be loaded while reset is held. A same-cycle beat load sees old data.
    always_ff @(posedge clk) begin
        if (init_we && in_range(init_addr)) begin
            mem[word_idx(init_addr)] <= init_data;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: one task per scenario, inline checks.
module tb_axi_read_responder;

    localparam int ID_W = 13;
    localparam int AW   = 64;
    localparam int DW   = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [ID_W-1:0] arid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic            init_we;
    logic [AW-1:0]   init_addr;
    logic [DW-1:0]   init_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle observations of the R channel, indexed from the first beat cycle.
    logic            o_valid   [32];
    logic            o_ready   [32];
    logic            o_last    [32];
    logic            o_arready [32];
    logic [1:0]      o_resp    [32];
    logic [DW-1:0]   o_data    [32];
    logic [ID_W-1:0] o_id      [32];

    axi_read_responder dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .init_we       (init_we),
        .init_addr     (init_addr),
        .init_data     (init_data)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] word_val(input int w);
        return 64'h1000 + 64'(w);
    endfunction

    // Driver: backdoor word write, called at a falling edge.
    task automatic init_write(input int word, input logic [DW-1:0] data);
        init_we   = 1'b1;
        init_addr = 64'(word) * 8;
        init_data = data;
        @(negedge clk);
        init_we   = 1'b0;
    endtask

    // Driver: waits (bounded) for arready, then performs one AR handshake.
    // Returns at the falling edge where beat 0 should be visible.
    task automatic issue_ar(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            arid    = id;
            araddr  = addr;
            arlen   = len;
            arsize  = size;
            arburst = burst;
            arvalid = 1'b1;
            @(negedge clk);
            arvalid = 1'b0;
        end
    endtask

    // Driver/monitor: runs ncyc cycles, rready always high (mode 0) or
    // 1,0,0 repeating (mode 1); optional backdoor write in cycle wr_cyc.
    task automatic observe(input int ncyc, input int mode, input int wr_cyc,
                           input int wr_word, input logic [DW-1:0] wr_data);
        for (int c = 0; c < ncyc; c++) begin
            rready    = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            init_we   = (c == wr_cyc);
            init_addr = 64'(wr_word) * 8;
            init_data = wr_data;
            o_valid[c]   = rvalid;
            o_ready[c]   = rready;
            o_last[c]    = rlast;
            o_arready[c] = arready;
            o_resp[c]    = rresp;
            o_data[c]    = rdata;
            o_id[c]      = rid;
            @(negedge clk);
        end
        rready  = 1'b0;
        init_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        // Preload while reset is held: backdoor must work during reset.
        for (int i = 0; i < 8; i++) init_write(i, word_val(i));
        init_write(4094, 64'hBEEF_0000 + 64'd4094);
        init_write(4095, 64'hBEEF_0000 + 64'd4095);
        n_tests++; if (arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b expected 0", arready); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        n_tests++; if (rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b expected 0", rlast); end
        n_tests++; if (rresp !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b expected 00", rresp); end
        n_tests++; if (rid !== '0) begin n_fail++; $display("FAIL reset_rid: got %h expected 0", rid); end
        n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (arready !== 1'b1) begin n_fail++; $display("FAIL reset_release_arready: got %b expected 1", arready); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_release_rvalid: got %b expected 0", rvalid); end
    endtask

    task automatic test_incr();
        bit ok;
        issue_ar(13'h5A, 64'h0, 8'd7, 3'd3, 2'b01, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL incr_ar: arready=%b expected 1 within bound", arready); end
        observe(10, 0, -1, 0, '0);
        for (int c = 0; c < 8; c++) begin
            n_tests++; if (o_valid[c] !== 1'b1) begin n_fail++; $display("FAIL incr_valid beat %0d: got %b expected 1", c, o_valid[c]); end
            n_tests++; if (o_data[c] !== word_val(c)) begin n_fail++; $display("FAIL incr_data beat %0d: got %h expected %h", c, o_data[c], word_val(c)); end
            n_tests++; if (o_last[c] !== (c == 7)) begin n_fail++; $display("FAIL incr_last beat %0d: got %b expected %b", c, o_last[c], (c == 7)); end
            n_tests++; if (o_resp[c] !== 2'b00) begin n_fail++; $display("FAIL incr_resp beat %0d: got %b expected 00", c, o_resp[c]); end
            n_tests++; if (o_id[c] !== 13'h5A) begin n_fail++; $display("FAIL incr_id beat %0d: got %h expected 5a", c, o_id[c]); end
            n_tests++; if (o_arready[c] !== 1'b0) begin n_fail++; $display("FAIL incr_arready_busy cycle %0d: got %b expected 0", c, o_arready[c]); end
        end
        n_tests++; if (o_valid[8] !== 1'b0) begin n_fail++; $display("FAIL incr_end_valid: got %b expected 0", o_valid[8]); end
        n_tests++; if (o_arready[8] !== 1'b1) begin n_fail++; $display("FAIL incr_end_arready: got %b expected 1", o_arready[8]); end
    endtask

    task automatic test_wrap();
        bit ok;
        int wo [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
        issue_ar(13'h123, 64'h28, 8'd7, 3'd3, 2'b10, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_ar: arready=%b expected 1 within bound", arready); end
        observe(9, 0, -1, 0, '0);
        for (int c = 0; c < 8; c++) begin
            n_tests++; if (o_data[c] !== word_val(wo[c])) begin n_fail++; $display("FAIL wrap_data beat %0d: got %h expected %h", c, o_data[c], word_val(wo[c])); end
            n_tests++; if (o_last[c] !== (c == 7)) begin n_fail++; $display("FAIL wrap_last beat %0d: got %b expected %b", c, o_last[c], (c == 7)); end
            n_tests++; if (o_resp[c] !== 2'b00) begin n_fail++; $display("FAIL wrap_resp beat %0d: got %b expected 00", c, o_resp[c]); end
        end
        n_tests++; if (o_id[0] !== 13'h123) begin n_fail++; $display("FAIL wrap_id: got %h expected 123", o_id[0]); end
        n_tests++; if (o_valid[8] !== 1'b0) begin n_fail++; $display("FAIL wrap_end_valid: got %b expected 0", o_valid[8]); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int k     = 0;
        int nlast = 0;
        issue_ar(13'h0F, 64'h0, 8'd3, 3'd3, 2'b01, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_ar: arready=%b expected 1 within bound", arready); end
        observe(12, 1, -1, 0, '0);
        for (int c = 0; c < 12; c++) begin
            if (o_valid[c] === 1'b1 && o_ready[c] === 1'b1) begin
                n_tests++; if (o_data[c] !== word_val(k)) begin n_fail++; $display("FAIL bp_data beat %0d: got %h expected %h", k, o_data[c], word_val(k)); end
                n_tests++; if (o_last[c] !== (k == 3)) begin n_fail++; $display("FAIL bp_last beat %0d: got %b expected %b", k, o_last[c], (k == 3)); end
                if (o_last[c] === 1'b1) nlast++;
                k++;
            end else if (o_valid[c] === 1'b1 && c < 11) begin
                n_tests++;
                if (o_valid[c+1] !== 1'b1 || o_data[c+1] !== o_data[c] ||
                    o_last[c+1] !== o_last[c] || o_resp[c+1] !== o_resp[c] || o_id[c+1] !== o_id[c]) begin
                    n_fail++;
                    $display("FAIL bp_hold cycle %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             c + 1, o_valid[c+1], o_data[c+1], o_last[c+1], o_data[c], o_last[c]);
                end
            end
        end
        n_tests++; if (k !== 4) begin n_fail++; $display("FAIL bp_beat_count: got %0d expected 4", k); end
        n_tests++; if (nlast !== 1) begin n_fail++; $display("FAIL bp_rlast_count: got %0d expected 1", nlast); end
    endtask

    task automatic test_boundary();
        bit ok;
        logic [DW-1:0] ed [4];
        logic [1:0]    er [4];
        ed = '{64'hBEEF_0000 + 64'd4094, 64'hBEEF_0000 + 64'd4095, 64'h0, 64'h0};
        er = '{2'b00, 2'b00, 2'b10, 2'b10};
        // Burst running off the top of memory.
        issue_ar(13'h1, 64'(4094) * 8, 8'd3, 3'd3, 2'b01, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL oob_ar: arready=%b expected 1 within bound", arready); end
        observe(5, 0, -1, 0, '0);
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (o_data[c] !== ed[c]) begin n_fail++; $display("FAIL oob_data beat %0d: got %h expected %h", c, o_data[c], ed[c]); end
            n_tests++; if (o_resp[c] !== er[c]) begin n_fail++; $display("FAIL oob_resp beat %0d: got %b expected %b", c, o_resp[c], er[c]); end
            n_tests++; if (o_last[c] !== (c == 3)) begin n_fail++; $display("FAIL oob_last beat %0d: got %b expected %b", c, o_last[c], (c == 3)); end
        end
        n_tests++; if (o_valid[4] !== 1'b0) begin n_fail++; $display("FAIL oob_end_valid: got %b expected 0", o_valid[4]); end
        // Wrong beat size: every beat errors.
        issue_ar(13'h2, 64'h0, 8'd1, 3'd2, 2'b01, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL size_ar: arready=%b expected 1 within bound", arready); end
        observe(3, 0, -1, 0, '0);
        for (int c = 0; c < 2; c++) begin
            n_tests++; if (o_resp[c] !== 2'b10) begin n_fail++; $display("FAIL size_resp beat %0d: got %b expected 10", c, o_resp[c]); end
            n_tests++; if (o_data[c] !== '0) begin n_fail++; $display("FAIL size_data beat %0d: got %h expected 0", c, o_data[c]); end
            n_tests++; if (o_last[c] !== (c == 1)) begin n_fail++; $display("FAIL size_last beat %0d: got %b expected %b", c, o_last[c], (c == 1)); end
        end
        n_tests++; if (o_valid[2] !== 1'b0) begin n_fail++; $display("FAIL size_end_valid: got %b expected 0", o_valid[2]); end
        // Illegal WRAP length: every beat errors, length still honoured.
        issue_ar(13'h3, 64'h0, 8'd2, 3'd3, 2'b10, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wraplen_ar: arready=%b expected 1 within bound", arready); end
        observe(4, 0, -1, 0, '0);
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (o_resp[c] !== 2'b10) begin n_fail++; $display("FAIL wraplen_resp beat %0d: got %b expected 10", c, o_resp[c]); end
            n_tests++; if (o_data[c] !== '0) begin n_fail++; $display("FAIL wraplen_data beat %0d: got %h expected 0", c, o_data[c]); end
            n_tests++; if (o_last[c] !== (c == 2)) begin n_fail++; $display("FAIL wraplen_last beat %0d: got %b expected %b", c, o_last[c], (c == 2)); end
        end
        n_tests++; if (o_valid[3] !== 1'b0) begin n_fail++; $display("FAIL wraplen_end_valid: got %b expected 0", o_valid[3]); end
    endtask

    task automatic test_fixed();
        bit ok;
        logic [DW-1:0] ed [4];
        ed = '{64'h1003, 64'h1003, 64'hCAFE_F00D, 64'hCAFE_F00D};
        issue_ar(13'h4, 64'h18, 8'd3, 3'd3, 2'b00, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fixed_ar: arready=%b expected 1 within bound", arready); end
        // Backdoor write to word 3 lands on the same edge that loads beat 1.
        observe(5, 0, 0, 3, 64'hCAFE_F00D);
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (o_data[c] !== ed[c]) begin n_fail++; $display("FAIL fixed_data beat %0d: got %h expected %h", c, o_data[c], ed[c]); end
            n_tests++; if (o_last[c] !== (c == 3)) begin n_fail++; $display("FAIL fixed_last beat %0d: got %b expected %b", c, o_last[c], (c == 3)); end
        end
        n_tests++; if (o_valid[4] !== 1'b0) begin n_fail++; $display("FAIL fixed_end_valid: got %b expected 0", o_valid[4]); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        logic [DW-1:0] exp_d;
        issue_ar(13'h77, 64'h0, 8'd7, 3'd3, 2'b01, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_ar: arready=%b expected 1 within bound", arready); end
        rready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (rdata !== word_val(c)) begin n_fail++; $display("FAIL rst_pre_data beat %0d: got %h expected %h", c, rdata, word_val(c)); end
            if (c == 2) reset = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid: got %b expected 0", rvalid); end
        n_tests++; if (rlast !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rlast: got %b expected 0", rlast); end
        n_tests++; if (arready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_arready: got %b expected 0", arready); end
        n_tests++; if (rid !== '0) begin n_fail++; $display("FAIL rst_mid_rid: got %h expected 0", rid); end
        @(negedge clk);
        reset  = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        n_tests++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rst_after_arready: got %b expected 1", arready); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_after_rvalid: got %b expected 0", rvalid); end
        // Memory must be intact, including the word rewritten earlier.
        issue_ar(13'h11, 64'h0, 8'd7, 3'd3, 2'b01, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_new_ar: arready=%b expected 1 within bound", arready); end
        observe(9, 0, -1, 0, '0);
        for (int c = 0; c < 8; c++) begin
            exp_d = (c == 3) ? 64'hCAFE_F00D : word_val(c);
            n_tests++; if (o_data[c] !== exp_d) begin n_fail++; $display("FAIL rst_new_data beat %0d: got %h expected %h", c, o_data[c], exp_d); end
            n_tests++; if (o_last[c] !== (c == 7)) begin n_fail++; $display("FAIL rst_new_last beat %0d: got %b expected %b", c, o_last[c], (c == 7)); end
        end
        n_tests++; if (o_id[0] !== 13'h11) begin n_fail++; $display("FAIL rst_new_id: got %h expected 11", o_id[0]); end
        n_tests++; if (o_valid[8] !== 1'b0) begin n_fail++; $display("FAIL rst_new_end_valid: got %b expected 0", o_valid[8]); end
    endtask

    initial begin
        reset     = 1'b1;
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;
        @(negedge clk);
        test_reset();
        test_incr();
        test_wrap();
        test_backpressure();
        test_boundary();
        test_fixed();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
